// File: rtl/rapid_pkg.sv
// Shared types for the rapid cache request protocol and the memory responder.
package rapid_pkg;

  localparam int WORD_WIDTH      = 4;
  localparam int MEM_MAX_LATENCY = 15;

  typedef enum logic {CACHE_READ, CACHE_WRITE} cache_rw;
  typedef enum logic [1:0] {CACHE_NOP, BYTE, HALF_WORD, WORD} cache_operation;
  typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_RESP} mem_state_t;

  // Lane enables assume natural alignment: a half uses addr[1], a word ignores addr.
  function automatic logic [3:0] cache_byte_en(cache_operation op, logic [1:0] a);
    logic [3:0] be;
    case (op)
      BYTE:      be = 4'b0001 << a;
      HALF_WORD: be = a[1] ? 4'b1100 : 4'b0011;
      WORD:      be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/rapid_mem_lane.sv
// Combinational lane logic: right-aligns read data and merges write data into a word.
module rapid_mem_lane
  import rapid_pkg::*;
(
  input  cache_operation          i_op,
  input  logic [1:0]              i_addr_lo,
  input  logic [WORD_WIDTH*8-1:0] i_wdata,
  input  logic [WORD_WIDTH*8-1:0] i_word,
  output logic [WORD_WIDTH*8-1:0] o_rdata,
  output logic [WORD_WIDTH*8-1:0] o_merged
);

  logic [3:0]              w_be;
  logic [WORD_WIDTH*8-1:0] w_lanedata;

  always_comb begin
    w_be = cache_byte_en(i_op, i_addr_lo);
    case (i_op)
      BYTE:      w_lanedata = {4{i_wdata[7:0]}};
      HALF_WORD: w_lanedata = {2{i_wdata[15:0]}};
      default:   w_lanedata = i_wdata;
    endcase
    o_merged = i_word;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (w_be[i]) o_merged[8*i +: 8] = w_lanedata[8*i +: 8];
    end
  end

  always_comb begin
    case (i_op)
      BYTE:      o_rdata = (i_word >> {i_addr_lo, 3'b000}) & 32'h0000_00FF;
      HALF_WORD: o_rdata = (i_word >> {i_addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
      WORD:      o_rdata = i_word;
      default:   o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/rapid_mem_responder.sv
// Responder for rapid cache requests backed by a word array with programmable latency.
// Define RAPID_MEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module rapid_mem_responder
  import rapid_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter int    ADDR_WIDTH  = 32,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  cache_rw               req_rw,
  input  cache_operation        req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MEM_MAX_LATENCY + 1);

  mem_state_t            r_state, w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  cache_rw               r_rw;
  cache_operation        r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic                  w_done, w_in_range, w_misalign, w_err, w_access, w_commit;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_word, w_lane_rdata, w_lane_merged;

  assign w_done     = (r_cnt == '0);
  assign w_in_range = r_addr[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS);
`ifdef RAPID_MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((r_op == HALF_WORD) && r_addr[0]) ||
                      ((r_op == WORD) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  // NOP never touches the array, so its address can never raise an error.
  assign w_err      = (r_op != CACHE_NOP) && (!w_in_range || w_misalign);
  assign w_access   = (r_op != CACHE_NOP) && !w_err;
  assign w_idx      = r_addr[IDX_W+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_commit   = (r_state == MEM_BUSY) && w_done && (r_rw == CACHE_WRITE) && w_access;

  rapid_mem_lane u_lane (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_word    (w_word),
    .o_rdata   (w_lane_rdata),
    .o_merged  (w_lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MEM_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MEM_IDLE: if (req_valid) w_next_state = MEM_BUSY;
      MEM_BUSY: if (w_done)    w_next_state = MEM_RESP;
      MEM_RESP: if (rsp_ready) w_next_state = MEM_IDLE;
      default:                 w_next_state = MEM_IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it stays low for the whole reset pulse.
  always_comb begin
    req_ready = rst_n && (r_state == MEM_IDLE);
    rsp_valid = (r_state == MEM_RESP);
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rw        <= CACHE_READ;
      r_op        <= CACHE_NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: if (req_valid) begin
          r_rw    <= req_rw;
          r_op    <= req_op;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_cnt   <= CNT_W'(LATENCY - 1);
        end
        MEM_BUSY: if (w_done) begin
          r_rsp_err   <= w_err;
          r_rsp_rdata <= ((r_rw == CACHE_READ) && w_access) ? w_lane_rdata : '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        MEM_RESP: if (rsp_ready) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= w_lane_merged;
  end

endmodule

// File: tb/tb_rapid_mem_responder.sv
// Directed self-checking bench for rapid_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_rapid_mem_responder;
  import rapid_pkg::*;

  localparam int LAT = 2;
`ifdef RAPID_MEM_MISALIGN_TRAP_EN
  localparam logic        MIS_ERR = 1'b1;
  localparam logic [31:0] MIS_EXP = 32'hDE5ABEEF;
`else
  localparam logic        MIS_ERR = 1'b0;
  localparam logic [31:0] MIS_EXP = 32'hA5A5A5A5;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  cache_rw        req_rw = CACHE_READ;
  cache_operation req_op = CACHE_NOP;
  logic [31:0]    req_addr = '0;
  logic [31:0]    req_wdata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;

  int cmp = 0;
  int mis = 0;

  always #5 clk = ~clk;

  rapid_mem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT),
    .ADDR_WIDTH  (32),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Issues one request from just after a rising edge; lat = edges from accept to rsp_valid (99 = timeout).
  task automatic do_txn(input cache_rw rw, input cache_operation op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat);
    req_rw = rw; req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    cmp++; if (req_ready !== 1'b0) begin mis++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    cmp++; if (rsp_valid !== 1'b0) begin mis++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    cmp++; if (rsp_rdata !== 32'h0) begin mis++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    cmp++; if (rsp_err !== 1'b0) begin mis++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    rst_n = 1'b1;
    #1;
    cmp++; if (req_ready !== 1'b1) begin mis++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_WRITE, WORD, 32'h10, 32'hDEADBEEF, rd, er, lat);
    cmp++; if (lat !== LAT) begin mis++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    cmp++; if (er !== 1'b0 || rd !== 32'h0) begin mis++; $display("FAIL wr_rsp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    do_txn(CACHE_READ, WORD, 32'h10, 32'h0, rd, er, lat);
    cmp++; if (lat !== LAT) begin mis++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    cmp++; if (rd !== 32'hDEADBEEF) begin mis++; $display("FAIL rd_word: got %h expected deadbeef", rd); end
    cmp++; if (er !== 1'b0) begin mis++; $display("FAIL rd_word_err: got %b expected 0", er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_WRITE, BYTE, 32'h12, 32'hFFFFFF5A, rd, er, lat);
    do_txn(CACHE_READ, BYTE, 32'h12, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h0000005A) begin mis++; $display("FAIL rd_byte: got %h expected 0000005a", rd); end
    do_txn(CACHE_READ, WORD, 32'h10, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'hDE5ABEEF) begin mis++; $display("FAIL rd_word_after_byte: got %h expected de5abeef", rd); end
  endtask

  task automatic test_half_range();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_READ, HALF_WORD, 32'h12, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h0000DE5A) begin mis++; $display("FAIL rd_half: got %h expected 0000de5a", rd); end
    do_txn(CACHE_READ, HALF_WORD, 32'h13, 32'h0, rd, er, lat);
    cmp++; if (er !== MIS_ERR || rd !== (MIS_ERR ? 32'h0 : 32'h0000DE5A)) begin
      mis++; $display("FAIL rd_half_misaligned: got err=%b rdata=%h expected err=%b", er, rd, MIS_ERR); end
    do_txn(CACHE_WRITE, WORD, 32'h0, 32'h11223344, rd, er, lat);
    do_txn(CACHE_WRITE, WORD, 32'h1000, 32'hCAFEF00D, rd, er, lat);
    cmp++; if (er !== 1'b1 || rd !== 32'h0) begin mis++; $display("FAIL wr_out_of_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_txn(CACHE_READ, WORD, 32'h1000, 32'h0, rd, er, lat);
    cmp++; if (er !== 1'b1 || rd !== 32'h0) begin mis++; $display("FAIL rd_out_of_range: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_txn(CACHE_READ, WORD, 32'h0, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h11223344) begin mis++; $display("FAIL word0_intact: got %h expected 11223344", rd); end
    do_txn(CACHE_READ, CACHE_NOP, 32'h10, 32'h0, rd, er, lat);
    cmp++; if (lat !== LAT || er !== 1'b0 || rd !== 32'h0) begin
      mis++; $display("FAIL nop: got lat=%0d err=%b rdata=%h expected lat=%0d err=0 rdata=0", lat, er, rd, LAT); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_WRITE, WORD, 32'h11, 32'hA5A5A5A5, rd, er, lat);
    cmp++; if (er !== MIS_ERR) begin mis++; $display("FAIL misaligned_wr_err: got %b expected %b", er, MIS_ERR); end
    do_txn(CACHE_READ, WORD, 32'h10, 32'h0, rd, er, lat);
    cmp++; if (rd !== MIS_EXP) begin mis++; $display("FAIL misaligned_wr_effect: got %h expected %h", rd, MIS_EXP); end
  endtask

  task automatic test_hold();
    int n;
    req_rw = CACHE_READ; req_op = WORD; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== MIS_EXP || rsp_err !== 1'b0) begin
        mis++; $display("FAIL hold_rsp[%0d]: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=0",
                        i, rsp_valid, rsp_rdata, rsp_err, MIS_EXP); end
      cmp++; if (req_ready !== 1'b0) begin mis++; $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mis++; $display("FAIL hold_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_WRITE, WORD, 32'h20, 32'h12345678, rd, er, lat);
    req_rw = CACHE_WRITE; req_op = WORD; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      mis++; $display("FAIL busy_reset_outputs: got valid=%b ready=%b rdata=%h err=%b expected all 0",
                      rsp_valid, req_ready, rsp_rdata, rsp_err); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    do_txn(CACHE_READ, WORD, 32'h20, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h12345678) begin mis++; $display("FAIL busy_reset_write_dropped: got %h expected 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    do_txn(CACHE_WRITE, WORD, 32'h40, 32'h01020304, rd, er, lat);
    do_txn(CACHE_WRITE, HALF_WORD, 32'h46, 32'h0000BEEF, rd, er, lat);
    do_txn(CACHE_WRITE, WORD, 32'h44, 32'h0, rd, er, lat);
    do_txn(CACHE_WRITE, BYTE, 32'h41, 32'h000000AA, rd, er, lat);
    do_txn(CACHE_READ, WORD, 32'h40, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h0102AA04) begin mis++; $display("FAIL b2b_word40: got %h expected 0102aa04", rd); end
    do_txn(CACHE_READ, WORD, 32'h44, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h00000000) begin mis++; $display("FAIL b2b_word44: got %h expected 00000000", rd); end
    do_txn(CACHE_WRITE, HALF_WORD, 32'h46, 32'h1234BEEF, rd, er, lat);
    do_txn(CACHE_READ, HALF_WORD, 32'h46, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h0000BEEF) begin mis++; $display("FAIL b2b_half46: got %h expected 0000beef", rd); end
    do_txn(CACHE_READ, BYTE, 32'h47, 32'h0, rd, er, lat);
    cmp++; if (rd !== 32'h000000BE || lat !== LAT) begin
      mis++; $display("FAIL b2b_byte47: got rdata=%h lat=%0d expected rdata=000000be lat=%0d", rd, lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_range();
    test_misalign();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
